// File: rtl/adder_wide_seq.sv
// Multi-cycle wide adder: one (32*WORDS)-bit addition computed LSW->MSW
// through a single shared 32-bit carry-select adder, with valid/ready on both sides.

module adder_cs_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] sum_o,
    output logic        c_o
);
    logic [16:0] lo_s;
    logic [16:0] hi0_s;
    logic [16:0] hi1_s;

    assign lo_s  = {1'b0, a_i[15:0]}  + {1'b0, b_i[15:0]}  + {16'd0, c_i};
    assign hi0_s = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]};
    assign hi1_s = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]} + 17'd1;

    // Upper half selected by the lower half's carry.
    always_comb begin
        sum_o[15:0] = lo_s[15:0];
        if (lo_s[16]) begin
            sum_o[31:16] = hi1_s[15:0];
            c_o          = hi1_s[16];
        end else begin
            sum_o[31:16] = hi0_s[15:0];
            c_o          = hi0_s[16];
        end
    end
endmodule

module adder_wide_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [32*WORDS-1:0]   inA,
    input  logic [32*WORDS-1:0]   inB,
    input  logic                  inCarry,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [32*WORDS-1:0]   outSum,
    output logic                  outCarry,
    output logic                  busy
);
    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          out_carry_q, out_carry_d;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [31:0]   add_a_s;
    logic [31:0]   add_b_s;
    logic [31:0]   add_sum_s;
    logic          add_c_s;

    assign add_a_s = op_a_q[32*int'(idx_q) +: 32];
    assign add_b_s = op_b_q[32*int'(idx_q) +: 32];

    adder_cs_32bit u_add (
        .a_i   (add_a_s),
        .b_i   (add_b_s),
        .c_i   (carry_q),
        .sum_o (add_sum_s),
        .c_o   (add_c_s)
    );

    // Next-state logic: capture in IDLE, one word per cycle in RUN, hold in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        out_carry_d = out_carry_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    op_a_d  = inA;
                    op_b_d  = inB;
                    carry_d = inCarry;
                    idx_d   = {IW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[32*int'(idx_q) +: 32] = add_sum_s;
                carry_d = add_c_s;
                if (idx_q == LAST_IDX) begin
                    out_carry_d = add_c_s;
                    idx_d       = {IW{1'b0}};
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= {IW{1'b0}};
            carry_q     <= 1'b0;
            op_a_q      <= {W{1'b0}};
            op_b_q      <= {W{1'b0}};
            sum_q       <= {W{1'b0}};
            out_carry_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            out_carry_q <= out_carry_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign outSum   = sum_q;
    assign outCarry = out_carry_q;
endmodule

// File: tb/tb_adder_wide_seq.sv
// Directed bench for adder_wide_seq: a 4-word instance for handshake and
// boundary cases, and a 1-word instance against a reference sum.

module tb_adder_wide_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         v4, rdy4, ov4, or4, c4, co4, busy4;
    logic [127:0] a4, b4, s4;
    logic         v1, rdy1, ov1, or1, c1, co1, busy1;
    logic [31:0]  a1, b1, s1;

    int n_checks = 0;
    int n_pass   = 0;

    adder_wide_seq #(.WORDS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .inValid(v4), .inReady(rdy4),
        .inA(a4), .inB(b4), .inCarry(c4), .outValid(ov4), .outReady(or4),
        .outSum(s4), .outCarry(co4), .busy(busy4)
    );

    adder_wide_seq #(.WORDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .inValid(v1), .inReady(rdy1),
        .inA(a1), .inB(b1), .inCarry(c1), .outValid(ov1), .outReady(or1),
        .outSum(s1), .outCarry(co1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called #1 after a rising edge while the 4-word instance is idle.
    task automatic op4(input string tag, input logic [127:0] a, input logic [127:0] b,
                       input logic cin, input logic [127:0] es, input logic ec,
                       input int bp, input bit pulse);
        int lat;
        bit stable;
        logic [127:0] held;
        check({tag, "_rdy"}, 129'(rdy4), 129'd1);
        v4 = 1'b1; a4 = a; b4 = b; c4 = cin;
        @(posedge clk); #1;
        v4 = 1'b0; a4 = ~a; b4 = ~b; c4 = ~cin;
        check({tag, "_busy"}, 129'(busy4), 129'd1);
        check({tag, "_rdy_run"}, 129'(rdy4), 129'd0);
        lat = 0;
        while (!ov4 && lat < 20) begin
            if (pulse && lat == 1) begin
                v4 = 1'b1; a4 = {128{1'b1}}; b4 = {128{1'b1}}; c4 = 1'b1;
            end else begin
                v4 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        v4 = 1'b0;
        check({tag, "_lat"}, 129'(lat), 129'd4);
        check({tag, "_sum"}, 129'(s4), 129'(es));
        check({tag, "_cout"}, 129'(co4), 129'(ec));
        if (bp > 0) begin
            stable = 1'b1;
            held = s4;
            repeat (bp) begin
                @(posedge clk); #1;
                if (!ov4 || s4 !== held || rdy4 || co4 !== ec) stable = 1'b0;
            end
            check({tag, "_hold"}, 129'(stable), 129'd1);
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        check({tag, "_ov_low"}, 129'(ov4), 129'd0);
        check({tag, "_rdy_back"}, 129'(rdy4), 129'd1);
    endtask

    task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [32:0] exp);
        int lat;
        v1 = 1'b1; a1 = a; b1 = b; c1 = cin; or1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; a1 = ~a; b1 = ~b;
        lat = 0;
        while (!ov1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 129'(lat), 129'd1);
        check({tag, "_res"}, 129'({co1, s1}), 129'(exp));
        @(posedge clk); #1;
        check({tag, "_rdy"}, 129'(rdy1), 129'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        rst_n = 1'b0;
        v4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        v1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        #12;
        check("rst_ov", 129'(ov4), 129'd0);
        check("rst_sum", 129'(s4), 129'd0);
        check("rst_cout", 129'(co4), 129'd0);
        check("rst_busy", 129'(busy4), 129'd0);
        check("rst_rdy", 129'(rdy4), 129'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        op4("t1", {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 0, 1'b0);
        op4("t2", 128'h00000000_00000000_00000000_FFFFFFFF, 128'd0, 1'b1,
            128'h00000000_00000000_00000001_00000000, 1'b0, 0, 1'b0);
        op4("t3", 128'h11111111_22222222_33333333_44444444,
            128'h01010101_02020202_03030303_04040404, 1'b0,
            128'h12121212_24242424_36363636_48484848, 1'b0, 10, 1'b0);
        op4("t4a", 128'h00000001_00000002_00000003_00000004,
            128'h10000000_20000000_30000000_40000000, 1'b0,
            128'h10000001_20000002_30000003_40000004, 1'b0, 0, 1'b1);
        op4("t4b", 128'h80000000_00000000_00000000_00000000,
            128'h80000000_00000000_00000000_00000000, 1'b0, 128'd0, 1'b1, 0, 1'b0);
        op4("t4c", {128{1'b1}}, {128{1'b1}}, 1'b1, {128{1'b1}}, 1'b1, 0, 1'b0);

        // Reset while the third word is about to be added.
        v4 = 1'b1; a4 = 128'h00000005_00000006_00000007_00000008; b4 = 128'd1; c4 = 1'b0;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_busy", 129'(busy4), 129'd1);
        check("t5_word0", 129'(s4[31:0]), 129'd9);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ov", 129'(ov4), 129'd0);
        check("t5_sum", 129'(s4), 129'd0);
        check("t5_rdy", 129'(rdy4), 129'd1);
        check("t5_busy0", 129'(busy4), 129'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_ov", 129'(ov4), 129'd0);
        op4("t5b", 128'h0000000A_0000000B_0000000C_0000000D, 128'd1, 1'b1,
            128'h0000000A_0000000B_0000000C_0000000F, 1'b0, 0, 1'b0);

        op1("t6", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            op1("t6r", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
